// File: rtl/phys_free_list_if.sv
// Rename/commit-side interface of the physical-register free list.
// FREELIST_CHECK_EN adds the fl_error_o double-free flag.
interface phys_free_list_if #(
    parameter int NUM_PHYS_REG = 64,
    parameter int FL_DEPTH     = 48
);
    localparam int PW = $clog2(NUM_PHYS_REG);
    localparam int CW = $clog2(FL_DEPTH + 1);

    logic          alloc_req_i;
    logic          alloc_ready_o;
    logic [PW-1:0] alloc_reg_o;
    logic          commit_v_i;
    logic [PW-1:0] commit_free_reg_i;
    logic          mispredict_i;
    logic [CW-1:0] free_count_o;
`ifdef FREELIST_CHECK_EN
    logic          fl_error_o;
`endif

    modport master (
        output alloc_req_i, commit_v_i, commit_free_reg_i, mispredict_i,
`ifdef FREELIST_CHECK_EN
        input  fl_error_o,
`endif
        input  alloc_ready_o, alloc_reg_o, free_count_o
    );

    modport slave (
        input  alloc_req_i, commit_v_i, commit_free_reg_i, mispredict_i,
`ifdef FREELIST_CHECK_EN
        output fl_error_o,
`endif
        output alloc_ready_o, alloc_reg_o, free_count_o
    );
endinterface

// File: rtl/phys_free_list.sv
// Physical-register free list with speculative/committed heads and one-cycle flush.
// Optional FREELIST_CHECK_EN keeps an is_free vector and flags double frees on fl_error_o.
module phys_free_list #(
    parameter int NUM_PHYS_REG = 64,
    parameter int NUM_ARCH_REG = 16,
    parameter int FL_DEPTH     = NUM_PHYS_REG - NUM_ARCH_REG
) (
    input logic               clk_i,
    input logic               reset_i,
    phys_free_list_if.slave   fl
);
    localparam int PW = $clog2(NUM_PHYS_REG);
    localparam int IW = $clog2(FL_DEPTH);
    localparam int CW = $clog2(FL_DEPTH + 1);

    logic [PW-1:0] entry [FL_DEPTH];
    logic [IW-1:0] spec_head;
    logic [IW-1:0] commit_head;
    logic [IW-1:0] tail;
    logic [CW-1:0] avail;

    logic          alloc_fire;
    logic [IW-1:0] commit_head_nxt;
    logic [CW-1:0] avail_nxt;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fl.alloc_ready_o = (avail != '0);
    assign fl.alloc_reg_o   = entry[spec_head];
    assign fl.free_count_o  = avail;

    always_comb begin
        alloc_fire      = fl.alloc_req_i && (avail != '0) && !fl.mispredict_i;
        commit_head_nxt = fl.commit_v_i ? ptr_inc(commit_head) : commit_head;
        avail_nxt       = avail;
        case ({fl.commit_v_i, alloc_fire})
            2'b10:   avail_nxt = avail + CW'(1);
            2'b01:   avail_nxt = avail - CW'(1);
            default: avail_nxt = avail;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entry[i] <= PW'(NUM_ARCH_REG + i);
            end
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= '0;
            avail       <= CW'(FL_DEPTH);
        end else begin
            // A committing instruction consumed the slot at commit_head, which is
            // also the tail slot, so the freed mapping lands there.
            if (fl.commit_v_i) begin
                entry[tail] <= fl.commit_free_reg_i;
                tail        <= ptr_inc(tail);
                commit_head <= commit_head_nxt;
            end
            if (fl.mispredict_i) begin
                spec_head <= commit_head_nxt;
                avail     <= CW'(FL_DEPTH);
            end else begin
                if (alloc_fire) begin
                    spec_head <= ptr_inc(spec_head);
                end
                avail <= avail_nxt;
            end
        end
    end

`ifdef FREELIST_CHECK_EN
    logic [NUM_PHYS_REG-1:0] is_free;
    logic [NUM_PHYS_REG-1:0] restore;
    logic                    fl_error;
    int                      outstanding;
    int                      slot;

    // Entries handed out but not yet committed become free again on a flush.
    always_comb begin
        restore     = '0;
        slot        = 0;
        outstanding = FL_DEPTH - int'(avail) - int'(fl.commit_v_i);
        for (int k = 0; k < FL_DEPTH; k++) begin
            slot = int'(commit_head_nxt) + k;
            if (slot >= FL_DEPTH) slot = slot - FL_DEPTH;
            if (fl.mispredict_i && (k < outstanding)) begin
                restore[entry[IW'(slot)]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int r = 0; r < NUM_PHYS_REG; r++) begin
                is_free[r] <= (r >= NUM_ARCH_REG);
            end
            fl_error <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_PHYS_REG; r++) begin
                if (restore[r]) begin
                    is_free[r] <= 1'b1;
                end else if (fl.commit_v_i && (fl.commit_free_reg_i == PW'(r))) begin
                    is_free[r] <= 1'b1;
                end else if (alloc_fire && (entry[spec_head] == PW'(r))) begin
                    is_free[r] <= 1'b0;
                end
            end
            if (fl.commit_v_i && is_free[fl.commit_free_reg_i]) begin
                fl_error <= 1'b1;
            end
        end
    end

    assign fl.fl_error_o = fl_error;
`endif
endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: queue-based reference model plus directed vectors.
module tb_phys_free_list;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phys_free_list_if #(.NUM_PHYS_REG(64), .FL_DEPTH(48)) fl();

    phys_free_list #(.NUM_PHYS_REG(64), .NUM_ARCH_REG(16), .FL_DEPTH(48)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .fl      (fl)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: free_q lists allocatable registers in allocation order,
    // infl_q lists allocated-but-uncommitted registers oldest first.
    int free_q [$];
    int infl_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        free_q = {};
        infl_q = {};
        for (int i = 16; i < 64; i++) free_q.push_back(i);
    endtask

    task automatic model_step(input bit req, input bit cv, input int r, input bit mp);
        bit fire;
        int a;
        fire = req && (free_q.size() != 0) && !mp;
        if (cv) begin
            if (infl_q.size() != 0) void'(infl_q.pop_front());
            free_q.push_back(r);
        end
        if (fire) begin
            a = free_q.pop_front();
            infl_q.push_back(a);
        end
        if (mp) begin
            for (int i = infl_q.size() - 1; i >= 0; i--) free_q.push_front(infl_q[i]);
            infl_q = {};
        end
    endtask

    task automatic step(input bit req, input bit cv, input int r, input bit mp);
        fl.alloc_req_i       = req;
        fl.commit_v_i        = cv;
        fl.commit_free_reg_i = 6'(r);
        fl.mispredict_i      = mp;
        @(posedge clk);
        model_step(req, cv, r, mp);
        @(negedge clk);
        fl.alloc_req_i  = 1'b0;
        fl.commit_v_i   = 1'b0;
        fl.mispredict_i = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst    = 1'b1;
        fl.alloc_req_i       = 1'b0;
        fl.commit_v_i        = 1'b0;
        fl.commit_free_reg_i = '0;
        fl.mispredict_i      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("model_ready", int'(fl.alloc_ready_o), int'(free_q.size() != 0));
            chk("model_count", int'(fl.free_count_o), free_q.size());
            if (free_q.size() != 0) chk("model_reg", int'(fl.alloc_reg_o), free_q[0]);
        end
    end

    initial begin
        int exp;
        int r;

        // Reset state and 48 back-to-back allocations
        do_reset();
        chk("rst_ready", int'(fl.alloc_ready_o), 1);
        chk("rst_reg", int'(fl.alloc_reg_o), 16);
        chk("rst_count", int'(fl.free_count_o), 48);
        for (int i = 0; i < 48; i++) begin
            chk("seq_reg", int'(fl.alloc_reg_o), 16 + i);
            step(1'b1, 1'b0, 0, 1'b0);
        end
        chk("empty_ready", int'(fl.alloc_ready_o), 0);
        chk("empty_count", int'(fl.free_count_o), 0);

        // Commit into an empty list with a concurrent request: no bypass
        step(1'b1, 1'b1, 5, 1'b0);
        chk("nobypass_ready", int'(fl.alloc_ready_o), 1);
        chk("nobypass_reg", int'(fl.alloc_reg_o), 5);
        chk("nobypass_count", int'(fl.free_count_o), 1);
        step(1'b0, 1'b0, 0, 1'b1);
        chk("flush1_count", int'(fl.free_count_o), 48);
        chk("flush1_reg", int'(fl.alloc_reg_o), 17);

        // Allocate 10, commit 3 freeing 2,3,4, then flush
        do_reset();
        repeat (10) step(1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 2, 1'b0);
        step(1'b0, 1'b1, 3, 1'b0);
        step(1'b0, 1'b1, 4, 1'b0);
        chk("pre_flush_count", int'(fl.free_count_o), 41);
        step(1'b0, 1'b0, 0, 1'b1);
        chk("flush2_count", int'(fl.free_count_o), 48);
        chk("flush2_reg", int'(fl.alloc_reg_o), 19);
        for (int i = 0; i < 48; i++) begin
            exp = (i < 45) ? 19 + i : 2 + (i - 45);
            chk("flush2_order", int'(fl.alloc_reg_o), exp);
            step(1'b1, 1'b0, 0, 1'b0);
        end
        chk("flush2_drained", int'(fl.alloc_ready_o), 0);

        // Sustained alloc+commit, pointers wrap several times
        do_reset();
        repeat (5) step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            r = infl_q[0];
            step(1'b1, 1'b1, r, 1'b0);
            chk("steady_count", int'(fl.free_count_o), 43);
            chk("steady_ready", int'(fl.alloc_ready_o), 1);
        end

        // Flush with simultaneous commit and request
        r   = infl_q[0];
        exp = infl_q[1];
        step(1'b1, 1'b1, r, 1'b1);
        chk("flush3_count", int'(fl.free_count_o), 48);
        chk("flush3_reg", int'(fl.alloc_reg_o), exp);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("flush3_next_count", int'(fl.free_count_o), 47);

        // Asynchronous reset mid-operation
        repeat (3) step(1'b1, 1'b0, 0, 1'b0);
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_count", int'(fl.free_count_o), 48);
        chk("async_reg", int'(fl.alloc_reg_o), 16);
        chk("async_ready", int'(fl.alloc_ready_o), 1);
        @(negedge clk);
        model_reset();
        rst    = 1'b0;
        chk_en = 1'b1;

`ifdef FREELIST_CHECK_EN
        // Double free of a still-free register
        do_reset();
        chk("err_rst", int'(fl.fl_error_o), 0);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("err_clean", int'(fl.fl_error_o), 0);
        step(1'b0, 1'b1, 40, 1'b0);
        chk("err_set", int'(fl.fl_error_o), 1);
        repeat (3) step(1'b0, 1'b0, 0, 1'b0);
        chk("err_hold", int'(fl.fl_error_o), 1);
        do_reset();
        chk("err_clear", int'(fl.fl_error_o), 0);
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
